// File: rtl/vx_kmu_block_dispatcher_if.sv
// vx_kmu_block_dispatcher_if: DCR write bus, per-channel block offers and completion pulses
interface vx_kmu_block_dispatcher_if #(
  parameter int NUM_OUTPUTS = 4,
  parameter int DIM_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32
);
  logic                   dcr_wr_valid;
  logic [ADDR_WIDTH-1:0]  dcr_wr_addr;
  logic [DATA_WIDTH-1:0]  dcr_wr_data;
  logic [NUM_OUTPUTS-1:0] req_valid;
  logic [NUM_OUTPUTS-1:0] req_ready;
  logic [DATA_WIDTH-1:0]  req_pc;
  logic [DIM_WIDTH-1:0]   req_bx;
  logic [DIM_WIDTH-1:0]   req_by;
  logic [DIM_WIDTH-1:0]   req_bz;
  logic [NUM_OUTPUTS-1:0] cpl_valid;
  modport master (
    input  dcr_wr_valid, dcr_wr_addr, dcr_wr_data, req_ready, cpl_valid,
    output req_valid, req_pc, req_bx, req_by, req_bz
  );
  modport slave (
    output dcr_wr_valid, dcr_wr_addr, dcr_wr_data, req_ready, cpl_valid,
    input  req_valid, req_pc, req_bx, req_by, req_bz
  );
endinterface

// File: rtl/vx_kmu_block_dispatcher.sv
// vx_kmu_block_dispatcher: DCR-launched 3-D grid walker dispatching one block per cycle round-robin
module vx_kmu_block_dispatcher #(
  parameter int NUM_OUTPUTS = 4,
  parameter int DIM_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] DCR_BASE = '0
) (
  input  logic clk,
  input  logic reset,
  output logic start,
  output logic busy,
  output logic done,
  vx_kmu_block_dispatcher_if.master bus
);
  localparam int CW = 3 * DIM_WIDTH;
  localparam int PW = NUM_OUTPUTS > 1 ? $clog2(NUM_OUTPUTS) : 1;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
  state_t state, next;
  logic [DATA_WIDTH-1:0] pc;
  logic [DIM_WIDTH-1:0] gx, gy, gz, bx, by, bz;
  logic [CW-1:0] total, issued, completed, cpl_next, prod;
  logic [PW-1:0] rr_ptr, off, tgt;
  logic [PW:0] sum;
  logic [2*NUM_OUTPUTS-1:0] dbl;
  logic [ADDR_WIDTH-1:0] offs;
  logic wr, launch, any, fire, last, x_last, y_last;
  assign offs     = bus.dcr_wr_addr - DCR_BASE;
  assign wr       = bus.dcr_wr_valid && state == IDLE;
  assign launch   = wr && offs == ADDR_WIDTH'(4);
  assign prod     = CW'(gx) * CW'(gy) * CW'(gz);
  assign cpl_next = completed + CW'($countones(bus.cpl_valid));
  assign last     = issued == total - 1'b1;
  assign x_last   = bx == gx - 1'b1;
  assign y_last   = by == gy - 1'b1;
  // rotate ready so bit 0 is the channel at rr_ptr; first set bit is the winner's offset
  assign dbl = {bus.req_ready, bus.req_ready} >> rr_ptr;
  always_comb begin
    off = '0;
    any = 1'b0;
    for (int j = NUM_OUTPUTS - 1; j >= 0; j--)
      if (dbl[j]) begin
        off = PW'(j);
        any = 1'b1;
      end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    tgt = sum >= (PW+1)'(NUM_OUTPUTS) ? PW'(sum - (PW+1)'(NUM_OUTPUTS)) : PW'(sum);
  end
  assign fire = state == DISPATCH && any;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb
    next = (state == IDLE && launch && prod != '0) ? DISPATCH :
           (state == DISPATCH && fire && last)     ? DRAIN :
           (state == DRAIN && cpl_next == total)   ? IDLE : state;
  always_comb begin
    busy          = state != IDLE;
    bus.req_valid = fire ? NUM_OUTPUTS'(1) << tgt : '0;
  end
  assign bus.req_pc = pc;
  assign bus.req_bx = bx;
  assign bus.req_by = by;
  assign bus.req_bz = bz;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      start     <= 1'b0;
      done      <= 1'b0;
      pc        <= '0;
      gx        <= '0;
      gy        <= '0;
      gz        <= '0;
      bx        <= '0;
      by        <= '0;
      bz        <= '0;
      total     <= '0;
      issued    <= '0;
      completed <= '0;
      rr_ptr    <= '0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      if (wr && offs == ADDR_WIDTH'(0)) pc <= bus.dcr_wr_data;
      if (wr && offs == ADDR_WIDTH'(1)) gx <= bus.dcr_wr_data[DIM_WIDTH-1:0];
      if (wr && offs == ADDR_WIDTH'(2)) gy <= bus.dcr_wr_data[DIM_WIDTH-1:0];
      if (wr && offs == ADDR_WIDTH'(3)) gz <= bus.dcr_wr_data[DIM_WIDTH-1:0];
      if (launch) begin
        start     <= 1'b1;
        done      <= prod == '0;
        total     <= prod;
        bx        <= '0;
        by        <= '0;
        bz        <= '0;
        issued    <= '0;
        completed <= '0;
      end
      if (fire) begin
        bx     <= x_last ? '0 : bx + 1'b1;
        by     <= x_last ? (y_last ? '0 : by + 1'b1) : by;
        bz     <= (x_last && y_last) ? bz + 1'b1 : bz;
        issued <= issued + 1'b1;
        rr_ptr <= tgt == PW'(NUM_OUTPUTS - 1) ? '0 : tgt + 1'b1;
      end
      if (state != IDLE) completed <= cpl_next;
      if (state == DRAIN && cpl_next == total) done <= 1'b1;
    end
endmodule

// File: tb/tb_vx_kmu_block_dispatcher.sv
// tb_vx_kmu_block_dispatcher: directed scenarios with hand-computed offers, payloads and done timing
module tb_vx_kmu_block_dispatcher;
  localparam int N = 4, DW = 16, AW = 12, DAW = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start, busy, done;
  int vectors = 0, miscompares = 0;
  vx_kmu_block_dispatcher_if #(.NUM_OUTPUTS(N), .DIM_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_WIDTH(DAW)) bus();
  vx_kmu_block_dispatcher #(.NUM_OUTPUTS(N), .DIM_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_WIDTH(DAW), .DCR_BASE('0)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic dcr(input logic [AW-1:0] a, input logic [DAW-1:0] d);
    bus.dcr_wr_valid = 1'b1;
    bus.dcr_wr_addr  = a;
    bus.dcr_wr_data  = d;
    tick;
    bus.dcr_wr_valid = 1'b0;
  endtask
  task automatic test_reset;
    bus.dcr_wr_valid = 1'b0;
    bus.dcr_wr_addr  = '0;
    bus.dcr_wr_data  = '0;
    bus.req_ready    = 4'hF;
    bus.cpl_valid    = '0;
    tick;
    vectors++;
    if ({start, busy, done, bus.req_valid, bus.req_pc, bus.req_bx, bus.req_by, bus.req_bz} !== '0) begin
      miscompares++;
      $display("FAIL reset got ctl=%b pc=%h idx=%h expected all zero", {start, busy, done, bus.req_valid}, bus.req_pc, {bus.req_bx, bus.req_by, bus.req_bz});
    end
    reset = 1'b1;
    tick;
  endtask
  task automatic test_basic;
    logic [6:0] ce;
    logic [47:0] ie;
    bus.req_ready = 4'hF;
    dcr(0, 32'h8000_0000); dcr(1, 2); dcr(2, 2); dcr(3, 1);
    dcr(4, 0);
    vectors++;
    if (bus.req_pc !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL basic_pc got %h expected 80000000", bus.req_pc);
    end
    for (int k = 0; k < 4; k++) begin
      ce = {k == 0, 1'b1, 1'b0, 4'(1 << k)};
      ie = {16'(k % 2), 16'(k / 2), 16'd0};
      vectors++;
      if ({start, busy, done, bus.req_valid} !== ce || {bus.req_bx, bus.req_by, bus.req_bz} !== ie) begin
        miscompares++;
        $display("FAIL basic_blk%0d got ctl=%b idx=%h expected ctl=%b idx=%h", k, {start, busy, done, bus.req_valid}, {bus.req_bx, bus.req_by, bus.req_bz}, ce, ie);
      end
      tick;
    end
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL basic_drain got ctl=%b expected 0100000", {start, busy, done, bus.req_valid});
    end
    for (int k = 0; k < 4; k++) begin
      bus.cpl_valid = 4'(1 << k);
      tick;
      bus.cpl_valid = '0;
      ce = {1'b0, k != 3, k == 3, 4'b0000};
      vectors++;
      if ({start, busy, done, bus.req_valid} !== ce) begin
        miscompares++;
        $display("FAIL basic_cpl%0d got ctl=%b expected %b", k, {start, busy, done, bus.req_valid}, ce);
      end
    end
    tick;
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0000000) begin
      miscompares++;
      $display("FAIL basic_idle got ctl=%b expected 0000000", {start, busy, done, bus.req_valid});
    end
  endtask
  task automatic test_skip_stalled;
    logic [6:0] ce;
    logic [47:0] ie;
    dcr(1, 3); dcr(2, 1);
    bus.req_ready = 4'b1101;
    dcr(4, 0);
    for (int k = 0; k < 3; k++) begin
      ce = {k == 0, 1'b1, 1'b0, k == 0 ? 4'b0001 : k == 1 ? 4'b0100 : 4'b1000};
      ie = {16'(k), 16'd0, 16'd0};
      vectors++;
      if ({start, busy, done, bus.req_valid} !== ce || {bus.req_bx, bus.req_by, bus.req_bz} !== ie) begin
        miscompares++;
        $display("FAIL skip_blk%0d got ctl=%b idx=%h expected ctl=%b idx=%h", k, {start, busy, done, bus.req_valid}, {bus.req_bx, bus.req_by, bus.req_bz}, ce, ie);
      end
      tick;
    end
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL skip_drain got ctl=%b expected 0100000", {start, busy, done, bus.req_valid});
    end
    bus.cpl_valid = 4'b1101;
    tick;
    bus.cpl_valid = '0;
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0010000) begin
      miscompares++;
      $display("FAIL skip_done got ctl=%b expected 0010000", {start, busy, done, bus.req_valid});
    end
    tick;
  endtask
  task automatic test_stall;
    logic [6:0] ce;
    dcr(1, 1);
    bus.req_ready = 4'b0000;
    dcr(4, 0);
    for (int k = 0; k < 5; k++) begin
      ce = {k == 0, 1'b1, 1'b0, 4'b0000};
      vectors++;
      if ({start, busy, done, bus.req_valid} !== ce || {bus.req_bx, bus.req_by, bus.req_bz} !== 48'd0) begin
        miscompares++;
        $display("FAIL stall_cyc%0d got ctl=%b idx=%h expected ctl=%b idx=0", k, {start, busy, done, bus.req_valid}, {bus.req_bx, bus.req_by, bus.req_bz}, ce);
      end
      tick;
    end
    bus.req_ready = 4'b0100;
    #1;
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0100100 || {bus.req_bx, bus.req_by, bus.req_bz} !== 48'd0) begin
      miscompares++;
      $display("FAIL stall_release got ctl=%b idx=%h expected ctl=0100100 idx=0", {start, busy, done, bus.req_valid}, {bus.req_bx, bus.req_by, bus.req_bz});
    end
    tick;
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL stall_drain got ctl=%b expected 0100000", {start, busy, done, bus.req_valid});
    end
    bus.cpl_valid = 4'b0100;
    tick;
    bus.cpl_valid = '0;
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0010000) begin
      miscompares++;
      $display("FAIL stall_done got ctl=%b expected 0010000", {start, busy, done, bus.req_valid});
    end
    tick;
  endtask
  task automatic test_empty_grid;
    bus.req_ready = 4'hF;
    dcr(2, 0);
    dcr(4, 0);
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b1010000) begin
      miscompares++;
      $display("FAIL empty_launch got ctl=%b expected 1010000", {start, busy, done, bus.req_valid});
    end
    tick;
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0000000) begin
      miscompares++;
      $display("FAIL empty_after got ctl=%b expected 0000000", {start, busy, done, bus.req_valid});
    end
  endtask
  task automatic test_busy_writes;
    logic [6:0] ce;
    logic [47:0] ie;
    dcr(1, 4); dcr(2, 1);
    bus.req_ready = 4'hF;
    dcr(4, 0);
    for (int k = 0; k < 4; k++) begin
      ce = {k == 0, 1'b1, 1'b0, 4'(1 << ((k + 3) % 4))};
      ie = {16'(k), 16'd0, 16'd0};
      vectors++;
      if ({start, busy, done, bus.req_valid} !== ce || {bus.req_bx, bus.req_by, bus.req_bz} !== ie) begin
        miscompares++;
        $display("FAIL busyw_blk%0d got ctl=%b idx=%h expected ctl=%b idx=%h", k, {start, busy, done, bus.req_valid}, {bus.req_bx, bus.req_by, bus.req_bz}, ce, ie);
      end
      if (k == 0) dcr(1, 1);
      else if (k == 1) dcr(4, 0);
      else tick;
    end
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL busyw_drain got ctl=%b expected 0100000", {start, busy, done, bus.req_valid});
    end
    bus.cpl_valid = 4'b1111;
    tick;
    bus.cpl_valid = '0;
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b0010000) begin
      miscompares++;
      $display("FAIL busyw_done got ctl=%b expected 0010000", {start, busy, done, bus.req_valid});
    end
    tick;
  endtask
  task automatic test_reset_mid;
    logic [6:0] ce;
    logic [47:0] ie;
    dcr(1, 2); dcr(2, 2); dcr(3, 2);
    bus.req_ready = 4'hF;
    dcr(4, 0);
    vectors++;
    if ({start, busy, done, bus.req_valid} !== 7'b1101000) begin
      miscompares++;
      $display("FAIL rmid_first got ctl=%b expected 1101000", {start, busy, done, bus.req_valid});
    end
    tick;
    reset = 1'b0;
    #1;
    vectors++;
    if ({start, busy, done, bus.req_valid, bus.req_pc, bus.req_bx, bus.req_by, bus.req_bz} !== '0) begin
      miscompares++;
      $display("FAIL rmid_async got ctl=%b pc=%h idx=%h expected all zero", {start, busy, done, bus.req_valid}, bus.req_pc, {bus.req_bx, bus.req_by, bus.req_bz});
    end
    tick;
    reset = 1'b1;
    dcr(1, 2); dcr(2, 2); dcr(3, 2);
    dcr(4, 0);
    for (int k = 0; k < 8; k++) begin
      ce = {k == 0, 1'b1, 1'b0, 4'(1 << (k % 4))};
      ie = {16'(k % 2), 16'((k / 2) % 2), 16'(k / 4)};
      vectors++;
      if ({start, busy, done, bus.req_valid} !== ce || {bus.req_bx, bus.req_by, bus.req_bz} !== ie) begin
        miscompares++;
        $display("FAIL rmid_blk%0d got ctl=%b idx=%h expected ctl=%b idx=%h", k, {start, busy, done, bus.req_valid}, {bus.req_bx, bus.req_by, bus.req_bz}, ce, ie);
      end
      tick;
    end
    for (int k = 0; k < 2; k++) begin
      bus.cpl_valid = 4'b1111;
      tick;
      bus.cpl_valid = '0;
      ce = {1'b0, k == 0, k == 1, 4'b0000};
      vectors++;
      if ({start, busy, done, bus.req_valid} !== ce) begin
        miscompares++;
        $display("FAIL rmid_cpl%0d got ctl=%b expected %b", k, {start, busy, done, bus.req_valid}, ce);
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_skip_stalled;
    test_stall;
    test_empty_grid;
    test_busy_writes;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
